// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode/phase types and helpers for the accumulator CPU sequencer
package cpu_pkg;

   localparam int OPC_W  = 3;
   localparam int PHASES = 8;
   localparam int PH_W   = $clog2(PHASES);

   typedef enum logic [OPC_W-1:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_e;

   typedef enum logic [PH_W-1:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_e;

   // Opcodes that read an operand from memory and load the accumulator.
   function automatic logic is_aluop(input opcode_e op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

endpackage

// File: rtl/cpu_phase_counter.sv
// rtl/cpu_phase_counter.sv - run/halt flags and phase register; memory wait under CPU_CTRL_MEM_WAIT_EN
import cpu_pkg::*;

module cpu_phase_counter (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [OPC_W-1:0] opcode,
`ifdef CPU_CTRL_MEM_WAIT_EN
   input  logic             mem_ready,
`endif
   output logic [PH_W-1:0]  phase,
   output logic             running,
   output logic             halted
);

   phase_e         phase_q;
   logic           running_q;
   logic           halted_q;
   logic           active;
   logic           hlt_now;
   logic           wait_ok;
   logic [PH_W-1:0] phase_nxt;

   // Sequencer is live only once started, enabled and not halted.
   always_comb begin
      active    = running_q & enable & ~halted_q;
      hlt_now   = active && (phase_q == OP_ADDR) && (opcode_e'(opcode) == HLT);
      phase_nxt = phase_q + 3'd1;
`ifdef CPU_CTRL_MEM_WAIT_EN
      // Fetch phases hold until the memory returns data.
      if ((phase_q == INST_FETCH) ||
          ((phase_q == OP_FETCH) && is_aluop(opcode_e'(opcode))))
         wait_ok = mem_ready;
      else
         wait_ok = 1'b1;
`else
      wait_ok = 1'b1;
`endif
   end

   // Phase advance, start latch and sticky halt; halt freezes phase at OP_ADDR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q   <= INST_ADDR;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         if (enable)
            running_q <= 1'b1;
         if (hlt_now)
            halted_q <= 1'b1;
         else if (active && wait_ok)
            phase_q <= phase_e'(phase_nxt);
      end
   end

   assign phase   = phase_q;
   assign running = running_q;
   assign halted  = halted_q;

endmodule

// File: rtl/cpu_mem_controller.sv
// rtl/cpu_mem_controller.sv - 8-phase strobe decoder for the accumulator CPU; mem_ready under CPU_CTRL_MEM_WAIT_EN
import cpu_pkg::*;

module cpu_mem_controller (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [OPC_W-1:0] opcode,
   input  logic             zero,
`ifdef CPU_CTRL_MEM_WAIT_EN
   input  logic             mem_ready,
`endif
   output logic             sel,
   output logic             rd,
   output logic             wr,
   output logic             data_e,
   output logic             ld_ir,
   output logic             inc_pc,
   output logic             ld_pc,
   output logic             ld_ac,
   output logic             halt,
   output logic [2:0]       phase
);

   logic    running;
   logic    halted;
   logic    active;
   logic    aluop;
   opcode_e op;

   cpu_phase_counter u_phase (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .opcode    (opcode),
`ifdef CPU_CTRL_MEM_WAIT_EN
      .mem_ready (mem_ready),
`endif
      .phase     (phase),
      .running   (running),
      .halted    (halted)
   );

   // Strobe decode from registered phase; everything is quiet unless active.
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      halt   = halted;
      op     = opcode_e'(opcode);
      aluop  = is_aluop(op);
      active = running & enable & ~halted;
      if (active) begin
         case (phase_e'(phase))
            INST_ADDR: begin
               sel = 1'b1;
            end
            INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            OP_ADDR: begin
               inc_pc = 1'b1;
               halt   = (op == HLT);
            end
            OP_FETCH: begin
               sel = aluop;
               rd  = aluop;
            end
            ALU_OP: begin
               sel    = aluop;
               rd     = aluop;
               inc_pc = (op == SKZ) & zero;
               ld_pc  = (op == JMP);
               data_e = (op == STO);
            end
            STORE: begin
               sel    = aluop;
               rd     = aluop;
               ld_ac  = aluop;
               inc_pc = (op == JMP);
               ld_pc  = (op == JMP);
               wr     = (op == STO);
               data_e = (op == STO);
            end
            default: begin
               sel = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_mem_controller.sv
// tb/tb_cpu_mem_controller.sv - scoreboard bench for cpu_mem_controller; mem wait test under CPU_CTRL_MEM_WAIT_EN
module tb_cpu_mem_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [2:0] opcode;
   logic       zero;
`ifdef CPU_CTRL_MEM_WAIT_EN
   logic       mem_ready;
`endif
   logic       sel, rd, wr, data_e, ld_ir, inc_pc, ld_pc, ld_ac, halt;
   logic [2:0] phase;

   typedef struct packed {
      logic [2:0] ph;
      logic [7:0] st;
      logic       hlt;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;

   // strobe byte = {sel, rd, wr, data_e, ld_ir, inc_pc, ld_pc, ld_ac}
   // phases 0..4 are opcode independent (HLT aside for halt)
   logic [39:0] pre       = 40'h80_C0_C8_C8_04;
   logic [23:0] tail_lda  = 24'hC0_C0_C1;
   logic [23:0] tail_sto  = 24'h00_10_30;
   logic [23:0] tail_skz1 = 24'h00_04_00;
   logic [23:0] tail_skz0 = 24'h00_00_00;
   logic [23:0] tail_jmp  = 24'h00_02_06;

   cpu_mem_controller dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .opcode    (opcode),
      .zero      (zero),
`ifdef CPU_CTRL_MEM_WAIT_EN
      .mem_ready (mem_ready),
`endif
      .sel       (sel),
      .rd        (rd),
      .wr        (wr),
      .data_e    (data_e),
      .ld_ir     (ld_ir),
      .inc_pc    (inc_pc),
      .ld_pc     (ld_pc),
      .ld_ac     (ld_ac),
      .halt      (halt),
      .phase     (phase)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_byte(input int p, input logic [23:0] tail);
      if (p < 5)
         return pre[(4-p)*8 +: 8];
      else
         return tail[(7-p)*8 +: 8];
   endfunction

   // Queue the expectation for the current clock interval, then move to the next.
   task automatic cyc(input logic [2:0] ph, input logic [7:0] st, input logic h, input string nm);
      exp_t e;
      e.ph  = ph;
      e.st  = st;
      e.hlt = h;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic run_phases(input int from, input int to, input logic [23:0] tail, input string nm);
      for (int p = from; p <= to; p++)
         cyc(p[2:0], exp_byte(p, tail), 1'b0, $sformatf("%s_p%0d", nm, p));
   endtask

   // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
   initial begin
      exp_t       e;
      string      nm;
      logic [7:0] act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {sel, rd, wr, data_e, ld_ir, inc_pc, ld_pc, ld_ac};
            checks++;
            if (phase !== e.ph) begin
               errors++;
               $display("FAIL %s phase got %0d expected %0d", nm, phase, e.ph);
            end
            checks++;
            if (act !== e.st) begin
               errors++;
               $display("FAIL %s strobes got %b expected %b", nm, act, e.st);
            end
            checks++;
            if (halt !== e.hlt) begin
               errors++;
               $display("FAIL %s halt got %b expected %b", nm, halt, e.hlt);
            end
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      enable = 1'b0;
      opcode = 3'd5;
      zero   = 1'b0;
`ifdef CPU_CTRL_MEM_WAIT_EN
      mem_ready = 1'b1;
`endif
      @(posedge clk);
      #1;
      cyc(3'd0, 8'h00, 1'b0, "reset");
      rst_n = 1'b1;
      cyc(3'd0, 8'h00, 1'b0, "not_enabled");
      enable = 1'b1;
      cyc(3'd0, 8'h00, 1'b0, "start_edge");

      opcode = 3'd5;
      run_phases(0, 7, tail_lda, "lda");
      opcode = 3'd6;
      run_phases(0, 7, tail_sto, "sto");
      opcode = 3'd1;
      zero   = 1'b1;
      run_phases(0, 7, tail_skz1, "skz_z1");
      zero   = 1'b0;
      run_phases(0, 7, tail_skz0, "skz_z0");
      opcode = 3'd7;
      run_phases(0, 7, tail_jmp, "jmp");

      // Pause in INST_LOAD: frozen phase, strobes off, reissue on resume.
      opcode = 3'd5;
      run_phases(0, 1, tail_lda, "pause");
      enable = 1'b0;
      for (int i = 0; i < 5; i++)
         cyc(3'd2, 8'h00, 1'b0, $sformatf("paused_%0d", i));
      enable = 1'b1;
      run_phases(2, 7, tail_lda, "resume");

`ifdef CPU_CTRL_MEM_WAIT_EN
      run_phases(0, 0, tail_lda, "wait");
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         cyc(3'd1, 8'hC0, 1'b0, $sformatf("mem_wait_%0d", i));
      mem_ready = 1'b1;
      run_phases(1, 7, tail_lda, "wait");
`endif

      // Halt: sticky at OP_ADDR until reset.
      opcode = 3'd0;
      run_phases(0, 3, tail_lda, "hlt");
      cyc(3'd4, 8'h04, 1'b1, "hlt_p4");
      for (int i = 0; i < 20; i++)
         cyc(3'd4, 8'h00, 1'b1, $sformatf("halted_%0d", i));
      rst_n = 1'b0;
      cyc(3'd0, 8'h00, 1'b0, "hlt_reset");
      rst_n  = 1'b1;
      opcode = 3'd5;
      cyc(3'd0, 8'h00, 1'b0, "restart_edge");
      run_phases(0, 7, tail_lda, "restart");
      cyc(3'd0, 8'h80, 1'b0, "wrap");

      for (int i = 0; i < 10 && exp_q.size() > 0; i++)
         @(posedge clk);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending %0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
